// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
// Holds the controller state encoding and the Amber UART register map.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POLL  = 2'd1,
        ST_GAP   = 2'd2,
        ST_WRITE = 2'd3
    } arb_state_t;

    localparam logic [15:0] UART_DR_OFS = 16'h0000;
    localparam logic [15:0] UART_FR_OFS = 16'h0018;
    localparam int          FR_TXFF_BIT = 5;

    // Requester indices are carried in 3 bits, enough for up to 8 requesters.
    localparam int          GRANT_IDX_W = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// last_grant, wrapping to the lowest index when nothing lies above it.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]       req,
    input  logic [GRANT_IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0]       grant,
    output logic [GRANT_IDX_W-1:0] grant_idx,
    output logic                   grant_any
);

    logic [N_REQ-1:0] above_mask;
    logic [N_REQ-1:0] req_above;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign above_mask[gi] = (GRANT_IDX_W'(gi) > last_grant);
        end
    endgenerate

    assign req_above = req & above_mask;
    assign grant_any = |req;

    // Lowest request above the pointer wins; otherwise the lowest overall.
    always_comb begin
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx = GRANT_IDX_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_above[i]) begin
                grant_idx = GRANT_IDX_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_idx == GRANT_IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Amber UART transmitter between byte-stream requesters: grants
// round-robin, polls FR until TX FIFO has room, then writes DR as a WB master.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          N_REQ     = 2,
    parameter logic [31:0] UART_BASE = 32'h1600_0000,
    parameter int          POLL_MAX  = 255,
    parameter int          WB_DWIDTH = 32,
    parameter int          WB_SWIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic                 o_busy,
    output logic                 o_drop,
    output logic [2:0]           o_drop_id,
    output logic [31:0]          o_wb_adr,
    output logic [WB_SWIDTH-1:0] o_wb_sel,
    output logic                 o_wb_we,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err
);

    localparam logic [7:0]  POLL_LIMIT = 8'(POLL_MAX);
    localparam logic [31:0] FR_ADR     = UART_BASE | {16'h0000, UART_FR_OFS};
    localparam logic [31:0] DR_ADR     = UART_BASE | {16'h0000, UART_DR_OFS};

    arb_state_t                 state_reg, state_next;
    logic [GRANT_IDX_W-1:0]     last_grant_reg, last_grant_next;
    logic [GRANT_IDX_W-1:0]     gid_reg, gid_next;
    logic [7:0]                 byte_reg, byte_next;
    logic [7:0]                 poll_cnt_reg, poll_cnt_next;
    logic                       drop_reg, drop_next;
    logic [2:0]                 drop_id_reg, drop_id_next;
    logic                       cyc_reg, cyc_next;
    logic                       we_reg, we_next;
    logic [31:0]                adr_reg, adr_next;
    logic [WB_DWIDTH-1:0]       dat_reg, dat_next;

    logic [N_REQ-1:0]           arb_grant;
    logic [GRANT_IDX_W-1:0]     arb_idx;
    logic                       arb_any;
    logic [7:0]                 req_byte;
    logic [7:0]                 poll_inc;
    logic                       handshake, ack_seen, err_seen, fifo_full;
    logic                       unused_wb_dat;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req        (i_req_valid),
        .last_grant (last_grant_reg),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_any  (arb_any)
    );

    always_comb begin
        req_byte = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_grant[k]) begin
                req_byte = i_req_data[8*k +: 8];
            end
        end
    end

    assign o_req_ready   = (state_reg == ST_IDLE) ? arb_grant : '0;
    assign handshake     = (state_reg == ST_IDLE) && arb_any;
    // Responses only count inside our own cycle; err outranks a coincident ack.
    assign err_seen      = i_wb_err && cyc_reg;
    assign ack_seen      = i_wb_ack && cyc_reg && !i_wb_err;
    assign fifo_full     = i_wb_dat[FR_TXFF_BIT];
    assign poll_inc      = sat_inc8(poll_cnt_reg);
    assign unused_wb_dat = ^i_wb_dat;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        gid_next        = gid_reg;
        byte_next       = byte_reg;
        poll_cnt_next   = poll_cnt_reg;
        drop_next       = 1'b0;
        drop_id_next    = drop_id_reg;

        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    byte_next       = req_byte;
                    gid_next        = arb_idx;
                    last_grant_next = arb_idx;
                    poll_cnt_next   = '0;
                    state_next      = ST_POLL;
                end
            end
            ST_POLL: begin
                if (err_seen || (ack_seen && fifo_full)) begin
                    poll_cnt_next = poll_inc;
                    if (poll_inc >= POLL_LIMIT) begin
                        drop_next    = 1'b1;
                        drop_id_next = gid_reg;
                        state_next   = ST_IDLE;
                    end else begin
                        state_next = ST_GAP;
                    end
                end else if (ack_seen) begin
                    state_next = ST_WRITE;
                end
            end
            ST_GAP: begin
                state_next = ST_POLL;
            end
            ST_WRITE: begin
                if (err_seen) begin
                    drop_next    = 1'b1;
                    drop_id_next = gid_reg;
                    state_next   = ST_IDLE;
                end else if (ack_seen) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Bus outputs follow the state being entered, so they only move on
        // edges into or out of POLL/WRITE and stay frozen while waiting.
        cyc_next = 1'b0;
        we_next  = 1'b0;
        adr_next = '0;
        dat_next = '0;
        if (state_next == ST_POLL) begin
            cyc_next = 1'b1;
            adr_next = FR_ADR;
        end else if (state_next == ST_WRITE) begin
            cyc_next = 1'b1;
            we_next  = 1'b1;
            adr_next = DR_ADR;
            dat_next = WB_DWIDTH'(byte_reg);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GRANT_IDX_W'(N_REQ - 1);
            gid_reg        <= '0;
            byte_reg       <= '0;
            poll_cnt_reg   <= '0;
            drop_reg       <= 1'b0;
            drop_id_reg    <= '0;
            cyc_reg        <= 1'b0;
            we_reg         <= 1'b0;
            adr_reg        <= '0;
            dat_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            gid_reg        <= gid_next;
            byte_reg       <= byte_next;
            poll_cnt_reg   <= poll_cnt_next;
            drop_reg       <= drop_next;
            drop_id_reg    <= drop_id_next;
            cyc_reg        <= cyc_next;
            we_reg         <= we_next;
            adr_reg        <= adr_next;
            dat_reg        <= dat_next;
        end
    end

    assign o_busy    = (state_reg != ST_IDLE);
    assign o_drop    = drop_reg;
    assign o_drop_id = drop_id_reg;
    assign o_wb_cyc  = cyc_reg;
    assign o_wb_stb  = cyc_reg;
    assign o_wb_we   = we_reg;
    assign o_wb_adr  = adr_reg;
    assign o_wb_dat  = dat_reg;
    assign o_wb_sel  = '1;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued requesters, a scripted UART
// slave and a transaction-level reference model of grants, bus traffic and drops.
module tb_uart_tx_arbiter;

    localparam int          N    = 3;
    localparam int          PM   = 4;
    localparam logic [31:0] BASE = 32'h1600_0000;
    localparam logic [31:0] FR_A = 32'h1600_0018;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          st;
        int          en;
    } txn_t;

    typedef struct {
        int f;
        bit werr;
    } plan_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           busy, drop;
    logic [2:0]     drop_id;
    logic [31:0]    wb_adr;
    logic [3:0]     wb_sel;
    logic           wb_we;
    logic [31:0]    wb_wdat;
    logic [31:0]    wb_rdat = '0;
    logic           wb_cyc, wb_stb;
    logic           wb_ack = 1'b0;
    logic           wb_err = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N), .UART_BASE(BASE), .POLL_MAX(PM), .WB_DWIDTH(32), .WB_SWIDTH(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .o_busy(busy), .o_drop(drop), .o_drop_id(drop_id),
        .o_wb_adr(wb_adr), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_dat(wb_wdat),
        .i_wb_dat(wb_rdat), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc_cnt = 0;
    int          model_last = N - 1;
    logic [7:0]  req_q [N][$];
    plan_t       plan_q[$];
    txn_t        obs_q[$], exp_q[$];
    int          gr_obs[$], gr_exp[$], gr_cyc[$];
    int          drop_obs[$], drop_exp[$];
    int          ready_cnt [N];
    bit          hold_bus = 0, wait_en = 0, noise_en = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Requesters: valid while their queue holds bytes, data is the queue head.
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                req_valid[k]        = (req_q[k].size() > 0);
                req_data[8*k +: 8]  = (req_q[k].size() > 0) ? req_q[k][0] : 8'h00;
            end
        end
    end

    // Negedge monitor plus scripted UART slave.
    initial begin
        bit          in_txn = 0;
        int          wait_left = 0;
        int          reads_in_byte = 0;
        plan_t       cur_plan;
        txn_t        cur_t;
        bit          full;
        logic [31:0] noise;
        int          r;
        cur_plan.f = 0;
        cur_plan.werr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wb_ack = 0; wb_err = 0; in_txn = 0; reads_in_byte = 0;
            end else begin
                if (req_ready != '0) begin
                    chk("ready onehot", $onehot(req_ready), 1);
                    chk("ready subset of valid", req_ready & ~req_valid, 0);
                end
                for (int k = 0; k < N; k++) begin
                    if (req_ready[k]) ready_cnt[k]++;
                    if (req_valid[k] && req_ready[k] && req_q[k].size() > 0) begin
                        gr_obs.push_back(k);
                        gr_cyc.push_back(cyc_cnt);
                        void'(req_q[k].pop_front());
                    end
                end
                if (drop) drop_obs.push_back(int'(drop_id));

                if (wb_cyc && wb_stb) begin
                    if (!in_txn) begin
                        in_txn    = 1;
                        cur_t.we  = wb_we;
                        cur_t.adr = wb_adr;
                        cur_t.dat = wb_wdat;
                        cur_t.sel = wb_sel;
                        cur_t.st  = cyc_cnt;
                        wait_left = wait_en ? $urandom_range(0, 2) : 0;
                    end else begin
                        chk("bus held adr", wb_adr, cur_t.adr);
                        chk("bus held we", wb_we, cur_t.we);
                        chk("bus held dat", wb_wdat, cur_t.dat);
                    end
                    if (hold_bus || wait_left > 0) begin
                        if (wait_left > 0) wait_left--;
                        wb_ack = 0; wb_err = 0;
                    end else begin
                        noise = noise_en ? $urandom() : 32'h0;
                        if (!wb_we) begin
                            if (reads_in_byte == 0) begin
                                if (plan_q.size() > 0) cur_plan = plan_q.pop_front();
                                else begin cur_plan.f = 0; cur_plan.werr = 0; end
                            end
                            reads_in_byte++;
                            full = (reads_in_byte <= cur_plan.f);
                            if (full) begin
                                wb_rdat = noise | 32'h20;
                                r = noise_en ? $urandom_range(0, 2) : 0;
                                wb_ack = (r != 1);
                                wb_err = (r != 0);
                                if (reads_in_byte == PM) reads_in_byte = 0;
                            end else begin
                                wb_rdat = noise & ~32'h20;
                                wb_ack = 1; wb_err = 0;
                            end
                        end else begin
                            wb_err = cur_plan.werr;
                            wb_ack = !cur_plan.werr || (noise_en && $urandom_range(0, 1) == 1);
                            reads_in_byte = 0;
                        end
                        cur_t.en = cyc_cnt;
                        obs_q.push_back(cur_t);
                        in_txn = 0;
                        $display("txn cyc=%0d we=%0b adr=%08h dat=%08h ack=%0b err=%0b",
                                 cyc_cnt, cur_t.we, cur_t.adr, cur_t.dat, wb_ack, wb_err);
                    end
                end else begin
                    in_txn = 0;
                    wb_err = 0;
                    wb_ack = noise_en && ($urandom_range(0, 1) == 1);
                    wb_rdat = noise_en ? $urandom() : 32'h0;
                end
            end
        end
    end

    task automatic load_byte(input int k, input logic [7:0] b, input int f, input bit werr);
        plan_t p;
        p.f = f;
        p.werr = werr;
        req_q[k].push_back(b);
        plan_q.push_back(p);
    endtask

    // Reference: round-robin service order, then per byte the reads, write and drop it implies.
    task automatic model_expect();
        logic [7:0] mq [N][$];
        plan_t      pq[$];
        plan_t      p;
        logic [7:0] b;
        txn_t       t;
        int         g, k, nreads;
        bit         any, more;
        for (int i = 0; i < N; i++) mq[i] = req_q[i];
        pq = plan_q;
        more = 1;
        while (more) begin
            any = 0;
            g = 0;
            for (int off = 1; off <= N; off++) begin
                k = (model_last + off) % N;
                if (!any && mq[k].size() > 0) begin g = k; any = 1; end
            end
            if (!any) more = 0;
            else begin
                b = mq[g].pop_front();
                if (pq.size() > 0) p = pq.pop_front();
                else begin p.f = 0; p.werr = 0; end
                model_last = g;
                gr_exp.push_back(g);
                nreads = (p.f >= PM) ? PM : p.f + 1;
                t.sel = 4'hF; t.st = 0; t.en = 0;
                for (int i = 0; i < nreads; i++) begin
                    t.we = 0; t.adr = FR_A; t.dat = 0;
                    exp_q.push_back(t);
                end
                if (p.f >= PM) drop_exp.push_back(g);
                else begin
                    t.we = 1; t.adr = BASE; t.dat = {24'h0, b};
                    exp_q.push_back(t);
                    if (p.werr) drop_exp.push_back(g);
                end
            end
        end
    endtask

    task automatic start_test();
        obs_q.delete(); exp_q.delete();
        gr_obs.delete(); gr_exp.delete(); gr_cyc.delete();
        drop_obs.delete(); drop_exp.delete();
        for (int k = 0; k < N; k++) ready_cnt[k] = 0;
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (req_q[k].size() > 0) return 0;
        return 1;
    endfunction

    task automatic run_wait(input string tag, input int budget);
        int n = 0;
        bit done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = all_empty() && !busy && (req_valid == '0);
        end
        chk({tag, " completes"}, done, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_results(input string name);
        int n;
        chk({name, " txn count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s txn%0d adr", name, i), obs_q[i].adr, exp_q[i].adr);
            chk($sformatf("%s txn%0d we", name, i), obs_q[i].we, exp_q[i].we);
            chk($sformatf("%s txn%0d sel", name, i), obs_q[i].sel, exp_q[i].sel);
            if (exp_q[i].we) chk($sformatf("%s txn%0d dat", name, i), obs_q[i].dat, exp_q[i].dat);
        end
        chk({name, " grant count"}, gr_obs.size(), gr_exp.size());
        n = (gr_obs.size() < gr_exp.size()) ? gr_obs.size() : gr_exp.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s grant%0d", name, i), gr_obs[i], gr_exp[i]);
        chk({name, " drop count"}, drop_obs.size(), drop_exp.size());
        n = (drop_obs.size() < drop_exp.size()) ? drop_obs.size() : drop_exp.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s drop%0d id", name, i), drop_obs[i], drop_exp[i]);
    endtask

    initial begin
        int nb;
        int waited;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset cyc", wb_cyc, 0);
        chk("reset stb", wb_stb, 0);
        chk("reset we", wb_we, 0);
        chk("reset adr", wb_adr, 0);
        chk("reset dat", wb_wdat, 0);
        chk("reset sel", wb_sel, 4'hF);
        chk("reset busy", busy, 0);
        chk("reset drop", drop, 0);
        chk("reset drop_id", drop_id, 0);
        chk("reset ready", req_ready, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("post-reset busy", busy, 0);

        // Single byte, FIFO has room: one FR read then one DR write.
        start_test();
        load_byte(0, 8'h41, 0, 0);
        model_expect();
        run_wait("A", 200);
        check_results("A");
        chk("A ready cycles", ready_cnt[0], 1);
        if (obs_q.size() >= 2 && gr_cyc.size() >= 1) begin
            chk("A read latency", obs_q[0].st, gr_cyc[0] + 1);
            chk("A write follows read", obs_q[1].st, obs_q[0].en + 1);
        end

        // Two requesters held valid: grants alternate.
        start_test();
        load_byte(0, 8'hA1, 0, 0);
        load_byte(1, 8'hB1, 0, 0);
        load_byte(0, 8'hA2, 0, 0);
        load_byte(1, 8'hB2, 0, 0);
        model_expect();
        run_wait("B", 400);
        check_results("B");

        // FIFO full three times: four reads with one idle bus cycle between.
        start_test();
        load_byte(2, 8'hC3, 3, 0);
        model_expect();
        run_wait("C", 300);
        check_results("C");
        if (obs_q.size() >= 5) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("C gap after read%0d", i), obs_q[i + 1].st, obs_q[i].en + 2);
            chk("C write after last read", obs_q[4].st, obs_q[3].en + 1);
        end

        // FIFO never drains: POLL_MAX reads then a drop.
        start_test();
        load_byte(1, 8'hD4, 10, 0);
        model_expect();
        run_wait("D", 300);
        check_results("D");
        chk("D drop_id held", drop_id, 1);

        // Error on the DR write drops the byte; next requester still served.
        start_test();
        load_byte(2, 8'hE5, 0, 1);
        load_byte(0, 8'hE6, 0, 0);
        model_expect();
        run_wait("E", 300);
        check_results("E");
        chk("E drop_id held", drop_id, 2);

        // Randomised rounds with wait states, bus errors and stray acks.
        wait_en = 1;
        noise_en = 1;
        for (int r = 0; r < 6; r++) begin
            start_test();
            for (int k = 0; k < N; k++) begin
                nb = $urandom_range(0, 4);
                for (int j = 0; j < nb; j++)
                    load_byte(k, 8'($urandom()), $urandom_range(0, 5), ($urandom_range(0, 9) == 0));
            end
            model_expect();
            run_wait($sformatf("R%0d", r), 3000);
            check_results($sformatf("R%0d", r));
        end
        wait_en = 0;
        noise_en = 0;

        // Reset while a poll is pending, then first grant returns to requester 0.
        start_test();
        hold_bus = 1;
        load_byte(0, 8'h55, 0, 0);
        waited = 0;
        while (!wb_cyc && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("F poll started", wb_cyc, 1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("F async cyc", wb_cyc, 0);
        chk("F async stb", wb_stb, 0);
        chk("F async busy", busy, 0);
        repeat (2) @(negedge clk);
        hold_bus = 0;
        for (int k = 0; k < N; k++) req_q[k].delete();
        plan_q.delete();
        model_last = N - 1;
        start_test();
        rst_n = 1;
        @(negedge clk);
        load_byte(1, 8'h66, 0, 0);
        load_byte(0, 8'h77, 0, 0);
        model_expect();
        run_wait("F", 300);
        check_results("F");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
